// File: rtl/mmio_int_ctrl_if.sv
// Bus and cpu interrupt handshake bundle for mmio_int_ctrl.
interface mmio_int_ctrl_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       hit;
    logic       int_ack;
    logic       int_ret;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;

    modport master (
        output addr, w_data, w_en, int_ack, int_ret,
        input  r_data, hit, int_req, int_en, int_vec
    );

    modport slave (
        input  addr, w_data, w_en, int_ack, int_ret,
        output r_data, hit, int_req, int_en, int_vec
    );
endinterface

// File: rtl/mmio_int_ctrl.sv
// Memory-mapped fixed-priority interrupt controller with request/ack/return handshake.
// Optional MMIO_INT_CTRL_LEVEL_EN adds a TRIG register selecting level-sensitive sources.
module mmio_int_ctrl #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic               wb_clk_i,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_i,
    mmio_int_ctrl_if.slave     bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [7:0] VEC_END = 8'(3 + NUM_SRC);
`ifdef MMIO_INT_CTRL_LEVEL_EN
    localparam logic [7:0] WIN_SZ = 8'(4 + NUM_SRC);
`else
    localparam logic [7:0] WIN_SZ = 8'(3 + NUM_SRC);
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2} state_t;

    state_t             state_r, state_n_s;
    logic [NUM_SRC-1:0] en_r, pend_r, src_q_r, pend_n_s;
    logic [NUM_SRC-1:0] set_s, w1c_s, ack_clr_s, req_s;
    logic               gie_r;
    logic [7:0]         vec_r [NUM_SRC];
    logic [IDX_W-1:0]   sel_r, sel_n_s, win_s, vidx_s;
    logic [7:0]         off_s, r_data_s, vec_n_s;
    logic               hit_s, wr_s, gie_off_s, int_req_r;
    logic [7:0]         int_en_r, int_vec_r;
`ifdef MMIO_INT_CTRL_LEVEL_EN
    logic [NUM_SRC-1:0] trig_r;
`endif

    assign off_s     = bus.addr - BASE_ADDR;
    assign hit_s     = (bus.addr >= BASE_ADDR) && (off_s < WIN_SZ);
    assign wr_s      = bus.w_en && hit_s;
    assign vidx_s    = IDX_W'(off_s - 8'd3);
    assign gie_off_s = wr_s && (off_s == 8'd2) && !bus.w_data[0];
    assign req_s     = pend_r & en_r;

    // Combinational register read mux
    always_comb begin
        r_data_s = 8'h00;
        if (hit_s) begin
            case (off_s)
                8'd0:    r_data_s = 8'(en_r);
                8'd1:    r_data_s = 8'(pend_r);
                8'd2:    r_data_s = {6'd0, (state_r != IDLE), gie_r};
                default: begin
                    if (off_s < VEC_END) begin
                        r_data_s = vec_r[vidx_s];
                    end else begin
`ifdef MMIO_INT_CTRL_LEVEL_EN
                        r_data_s = 8'(trig_r);
`else
                        r_data_s = 8'h00;
`endif
                    end
                end
            endcase
        end else begin
            r_data_s = 8'h00;
        end
    end

    // Configuration registers written from the bus
    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            en_r  <= '0;
            gie_r <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) vec_r[i] <= 8'h00;
`ifdef MMIO_INT_CTRL_LEVEL_EN
            trig_r <= '0;
`endif
        end else if (wr_s) begin
            case (off_s)
                8'd0:    en_r  <= bus.w_data[NUM_SRC-1:0];
                8'd1:    ;
                8'd2:    gie_r <= bus.w_data[0];
                default: begin
                    if (off_s < VEC_END) vec_r[vidx_s] <= bus.w_data;
`ifdef MMIO_INT_CTRL_LEVEL_EN
                    else trig_r <= bus.w_data[NUM_SRC-1:0];
`endif
                end
            endcase
        end
    end

    // Pending update: a new set always beats W1C or ack clear on the same bit
    always_comb begin
        w1c_s = '0;
        if (wr_s && (off_s == 8'd1)) begin
            w1c_s = bus.w_data[NUM_SRC-1:0];
        end else begin
            w1c_s = '0;
        end
`ifdef MMIO_INT_CTRL_LEVEL_EN
        set_s = (trig_r & src_i) | (~trig_r & src_i & ~src_q_r);
`else
        set_s = src_i & ~src_q_r;
`endif
        pend_n_s = (pend_r & ~w1c_s & ~ack_clr_s) | set_s;
    end

    // Lowest-index winner among enabled pending sources
    always_comb begin
        win_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            win_s = req_s[i] ? IDX_W'(i) : win_s;
        end
    end

    // FSM next state, latched selection and ack clear
    always_comb begin
        state_n_s = state_r;
        sel_n_s   = sel_r;
        vec_n_s   = int_vec_r;
        ack_clr_s = '0;
        case (state_r)
            IDLE: begin
                if (gie_r && (req_s != '0)) begin
                    state_n_s = REQ;
                    sel_n_s   = win_s;
                    vec_n_s   = vec_r[win_s];
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                if (gie_off_s) begin
                    state_n_s = IDLE;
                end else if (bus.int_ack) begin
                    state_n_s        = SVC;
                    ack_clr_s[sel_r] = 1'b1;
                end else begin
                    state_n_s = REQ;
                end
            end
            SVC: begin
                if (bus.int_ret) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = SVC;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State, pending, edge history and registered cpu-side outputs
    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            pend_r    <= '0;
            src_q_r   <= '0;
            int_req_r <= 1'b0;
            int_en_r  <= 8'h01;
            int_vec_r <= 8'h00;
        end else begin
            state_r   <= state_n_s;
            sel_r     <= sel_n_s;
            pend_r    <= pend_n_s;
            src_q_r   <= src_i;
            int_req_r <= (state_n_s == REQ);
            int_en_r  <= (state_n_s == IDLE) ? 8'h01 : 8'h00;
            int_vec_r <= vec_n_s;
        end
    end

    assign bus.r_data  = r_data_s;
    assign bus.hit     = hit_s;
    assign bus.int_req = int_req_r;
    assign bus.int_en  = int_en_r;
    assign bus.int_vec = int_vec_r;
endmodule

// File: tb/tb_mmio_int_ctrl.sv
// Directed self-checking bench for mmio_int_ctrl (NUM_SRC=4, BASE_ADDR=8'hF0).
module tb_mmio_int_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src;
    int         n_checks = 0;
    int         n_errors = 0;

    mmio_int_ctrl_if bus ();

    mmio_int_ctrl #(.NUM_SRC(4), .BASE_ADDR(8'hF0)) dut (
        .wb_clk_i (clk),
        .reset    (rst),
        .src_i    (src),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr   = a;
        bus.w_data = d;
        bus.w_en   = 1'b1;
        step(1);
        bus.w_en   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.addr = a;
        #1;
        check_eq(tag, bus.r_data, exp);
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        step(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        bus.int_ret = 1'b1;
        step(1);
        bus.int_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = 4'h0;
        bus.addr = 8'h00; bus.w_data = 8'h00; bus.w_en = 1'b0;
        bus.int_ack = 1'b0; bus.int_ret = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        // reset state
        for (int a = 8'hF0; a <= 8'hF6; a++) rd_check("rst_reg", 8'(a), 8'h00);
        check_eq("rst_int_en", bus.int_en, 8'h01);
        check_eq("rst_int_req", 8'(bus.int_req), 8'h00);
        check_eq("rst_int_vec", bus.int_vec, 8'h00);
        bus.addr = 8'hF0; #1; check_eq("hit_base", 8'(bus.hit), 8'h01);
        bus.addr = 8'hEF; #1; check_eq("hit_below", 8'(bus.hit), 8'h00);
`ifdef MMIO_INT_CTRL_LEVEL_EN
        bus.addr = 8'hF7; #1; check_eq("hit_trig", 8'(bus.hit), 8'h01);
        rd_check("rst_trig", 8'hF7, 8'h00);
`else
        bus.addr = 8'hF7; #1; check_eq("hit_past_end", 8'(bus.hit), 8'h00);
        rd_check("rd_past_end", 8'hF7, 8'h00);
`endif

        // single source request / ack / return
        wr(8'hF4, 8'h40); wr(8'hF0, 8'h02); wr(8'hF2, 8'h01);
        src = 4'b0010; step(1); src = 4'h0;
        rd_check("t2_pend", 8'hF1, 8'h02);
        check_eq("t2_no_req_yet", 8'(bus.int_req), 8'h00);
        step(1);
        check_eq("t2_req", 8'(bus.int_req), 8'h01);
        check_eq("t2_vec", bus.int_vec, 8'h40);
        check_eq("t2_en_req", bus.int_en, 8'h00);
        pulse_ack();
        rd_check("t2_pend_ack", 8'hF1, 8'h00);
        check_eq("t2_req_svc", 8'(bus.int_req), 8'h00);
        rd_check("t2_in_svc", 8'hF2, 8'h03);
        pulse_ret();
        check_eq("t2_en_ret", bus.int_en, 8'h01);
        rd_check("t2_ctrl_idle", 8'hF2, 8'h01);

        // priority between simultaneous sources
        wr(8'hF0, 8'h0F); wr(8'hF3, 8'h20); wr(8'hF6, 8'h80);
        src = 4'b1001; step(1); src = 4'h0;
        rd_check("t3_pend", 8'hF1, 8'h09);
        step(1);
        check_eq("t3_vec_first", bus.int_vec, 8'h20);
        pulse_ack();
        rd_check("t3_pend_left", 8'hF1, 8'h08);
        pulse_ret();
        check_eq("t3_idle_gap", 8'(bus.int_req), 8'h00);
        step(1);
        check_eq("t3_req_second", 8'(bus.int_req), 8'h01);
        check_eq("t3_vec_second", bus.int_vec, 8'h80);
        pulse_ack(); pulse_ret();

        // masked source, then enable; set beats W1C
        wr(8'hF0, 8'h0B);
        src = 4'b0100; step(1); src = 4'h0;
        step(2);
        check_eq("t4_masked", 8'(bus.int_req), 8'h00);
        rd_check("t4_pend", 8'hF1, 8'h04);
        wr(8'hF0, 8'h04);
        step(1);
        check_eq("t4_req", 8'(bus.int_req), 8'h01);
        check_eq("t4_vec", bus.int_vec, 8'h00);
        src = 4'b0100; wr(8'hF1, 8'h04); src = 4'h0;
        rd_check("t4_set_wins", 8'hF1, 8'h04);
        pulse_ack();
        rd_check("t4_pend_ack", 8'hF1, 8'h00);
        pulse_ret();

        // GIE drop during REQ, then reset during SVC
        wr(8'hF0, 8'h02);
        src = 4'b0010; step(1); src = 4'h0;
        step(1);
        check_eq("t5_req", 8'(bus.int_req), 8'h01);
        check_eq("t5_vec", bus.int_vec, 8'h40);
        wr(8'hF2, 8'h00);
        check_eq("t5_gie_drop", 8'(bus.int_req), 8'h00);
        rd_check("t5_ctrl_idle", 8'hF2, 8'h00);
        rd_check("t5_pend_kept", 8'hF1, 8'h02);
        wr(8'hF2, 8'h01);
        step(1);
        check_eq("t5_req_again", 8'(bus.int_req), 8'h01);
        pulse_ack();
        rd_check("t5_in_svc", 8'hF2, 8'h03);
        rst = 1'b1; #1;
        check_eq("t5_rst_int_en", bus.int_en, 8'h01);
        check_eq("t5_rst_int_req", 8'(bus.int_req), 8'h00);
        check_eq("t5_rst_int_vec", bus.int_vec, 8'h00);
        for (int a = 8'hF0; a <= 8'hF6; a++) rd_check("t5_rst_reg", 8'(a), 8'h00);
        step(1);
        rst = 1'b0;
        step(1);

`ifdef MMIO_INT_CTRL_LEVEL_EN
        // level-sensitive source
        wr(8'hF0, 8'h01); wr(8'hF3, 8'h20); wr(8'hF2, 8'h01); wr(8'hF7, 8'h01);
        rd_check("t6_trig", 8'hF7, 8'h01);
        src = 4'b0001; step(1);
        rd_check("t6_pend", 8'hF1, 8'h01);
        step(1);
        check_eq("t6_req", 8'(bus.int_req), 8'h01);
        check_eq("t6_vec", bus.int_vec, 8'h20);
        pulse_ack();
        rd_check("t6_pend_held", 8'hF1, 8'h01);
        pulse_ret();
        step(1);
        check_eq("t6_req_again", 8'(bus.int_req), 8'h01);
        pulse_ack();
        src = 4'h0;
        wr(8'hF1, 8'h01);
        rd_check("t6_pend_clr", 8'hF1, 8'h00);
        pulse_ret();
        step(3);
        check_eq("t6_no_req", 8'(bus.int_req), 8'h00);
        rd_check("t6_pend_final", 8'hF1, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_int_ctrl.md
Name: mmio_int_ctrl

Overview:
- Parametrised, memory-mapped interrupt controller for the jacaranda-8 computer top.
- Replaces the single hard-wired int_vec register (address 250) and the int_en toggle logic.
- Serves NUM_SRC peripheral sources (UART rx, LED4 done, timers, ...), each with its own mask and vector, with fixed priority and a request/ack/return handshake to the cpu.
- Sits beside data_mem on the rs_data/rd_data/mem_w_en bus; the top muxes r_data into mem_r_data when hit=1.

Parameters:
- NUM_SRC, 4, number of interrupt sources, legal range 1..8.
- BASE_ADDR, 8'hF0, first byte address of the register window. Window spans 3+NUM_SRC bytes and must not wrap past 8'hFF.

Ports:
- wb_clk_i  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  8  bus address (cpu rs_data).
- w_data  in  8  bus write data (cpu rd_data).
- w_en  in  1  bus write strobe (cpu mem_w_en).
- r_data  out  8  combinational read data; 8'h00 when hit=0.
- hit  out  1  combinational; 1 when addr is inside the window.
- src_i  in  NUM_SRC  interrupt source lines, synchronous to wb_clk_i.
- int_ack  in  1  one-cycle pulse; cpu has taken the interrupt and jumped to int_vec.
- int_ret  in  1  one-cycle pulse; cpu has executed return-from-interrupt.
- int_req  out  1  interrupt request to cpu.
- int_en  out  8  8'h01 when a new interrupt may be taken, else 8'h00.
- int_vec  out  8  handler address of the interrupt being requested or serviced.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 EN: RW. Per-source mask in bits [NUM_SRC-1:0]; upper bits read 0.
  - +1 PEND: read returns pending bits. Write-1-to-clear.
  - +2 CTRL: bit0 GIE, RW. bit1 IN_SVC, RO, 1 while state≠IDLE. Other bits read 0.
  - +3+i VEC[i]: RW, 8-bit handler address of source i.
- Writes take effect on the clock edge where w_en=1 and hit=1. Reads are combinational, zero latency.
- Edge detect: src_q holds src_i delayed one cycle. Rising edge (src_i & ~src_q) sets PEND[i] on the next edge.
- Simultaneous set and W1C on the same bit: set wins, and PEND stays 1.
- Arbitration: lowest index among (PEND & EN) wins, evaluated only in IDLE.
- FSM states:
  - IDLE: int_req=0, int_en=8'h01. If GIE=1 and (PEND & EN)≠0, latch sel=winner and int_vec=VEC[sel], then go to REQ.
  - REQ: int_req=1, int_en=8'h00. On int_ack, clear PEND[sel] (set-wins rule still applies) and go to SVC. Writing GIE=0 while in REQ drops int_req and returns to IDLE without clearing PEND.
  - SVC: int_req=0, int_en=8'h00, int_vec held. On int_ret, go to IDLE.
  - int_ack outside REQ and int_ret outside SVC are ignored.
- No nesting: edges arriving during REQ/SVC only set PEND.
- One IDLE cycle always separates consecutive interrupts.
- Writes to VEC[sel] during REQ/SVC do not change the latched int_vec.
- Reset values: EN=0, PEND=0, GIE=0, VEC[*]=0, src_q=0, state=IDLE, sel=0, int_req=0, int_en=8'h01, int_vec=8'h00.
- Reset is honoured mid-operation from any state, with no pending retained.

Optional Feature:
- Macro: MMIO_INT_CTRL_LEVEL_EN.
- When defined:
  - Adds register TRIG at BASE_ADDR+3+NUM_SRC (RW, reset 0). The window grows by one byte.
  - TRIG[i]=1 makes source i level-sensitive: PEND[i] is set every cycle src_i=1, so W1C has no lasting effect while the line is high.
  - TRIG[i]=0 keeps source i edge-triggered.
- When undefined: all sources are edge-triggered, that address is outside the window (hit=0), and no TRIG storage exists.

Test Plan:
- Reset, then read all offsets. Expect 0 everywhere; int_en=8'h01, int_req=0, int_vec=8'h00.
- Program VEC[1]=8'h40, EN=8'h02, GIE=1. Pulse src_i[1] for one cycle. Expect PEND=8'h02 one edge later and int_req=1 with int_vec=8'h40 the following edge. Pulse int_ack: expect PEND=0, int_req=0, IN_SVC=1. Pulse int_ret: expect int_en=8'h01.
- Set EN=8'h0F, GIE=1, VEC[0]=8'h20, VEC[3]=8'h80. Raise src_i[3] and src_i[0] in the same cycle. Expect int_vec=8'h20 first. After ack and ret, expect int_vec=8'h80 after one IDLE cycle.
- Set src_i[2] pending while EN[2]=0. Expect no int_req. Write EN=8'h04: expect int_req next edge. Write PEND=8'h04 in the same cycle as a new src_i[2] rising edge: expect PEND[2]=1.
- In REQ with sel=1, write GIE=0. Expect int_req=0 and state IDLE, PEND[1] still 1. Write GIE=1: expect int_req again. Assert reset during SVC: expect all registers 0 and int_en=8'h01 immediately.
- MMIO_INT_CTRL_LEVEL_EN defined: set TRIG=8'h01 and hold src_i[0]=1. Service it: expect int_req to reassert after int_ret. Drop src_i[0], then W1C PEND=8'h01: expect PEND=0 and no further requests.
